// File: rtl/tv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tv_pkg
//  Description : Raster and VRAM constants shared by the TV output path, plus
//                the fetch state encoding used by the pixel fetcher.
//  Revision    : 1.0 - initial release
// ============================================================================
package tv_pkg;

    // Raster geometry (pixels / lines)
    localparam int H_ACTIVE  = 512;
    localparam int H_TOTAL   = 640;
    localparam int V_ACTIVE  = 287;
    localparam int V_TOTAL   = 309;

    // Framebuffer word geometry
    localparam int WORD_BITS = 16;
    localparam int VRAM_AW   = 14;

    // Fetch FSM: at most one VRAM read outstanding at a time
    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_REQ  = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/tv_shift16.sv
`default_nettype none
// ============================================================================
//  Module      : tv_shift16
//  Description : 16-bit load/shift register, MSB first, with a registered
//                serial output bit.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n : clock, synchronous active-low reset
//    load       : take load_data; its MSB goes straight to bit_out
//    advance    : emit current MSB on bit_out and shift left
//    blank      : force bit_out low (blanking interval)
//    load_data  : word to load
//    bit_out    : serialized pixel (registered)
// ============================================================================
module tv_shift16
    import tv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 advance,
    input  logic                 blank,
    input  logic [WORD_BITS-1:0] load_data,
    output logic                 bit_out
);

    logic [WORD_BITS-1:0] shreg;

    // On load the first pixel leaves immediately, so the register keeps
    // only the remaining 15 bits already shifted into position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_out <= 1'b0;
        end else if (load) begin
            bit_out <= load_data[WORD_BITS-1];
            shreg   <= {load_data[WORD_BITS-2:0], 1'b0};
        end else if (advance) begin
            bit_out <= shreg[WORD_BITS-1];
            shreg   <= {shreg[WORD_BITS-2:0], 1'b0};
        end else if (blank) begin
            bit_out <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tv_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tv_pixel_fetch
//  Description : Video-RAM word fetcher and 1-bpp pixel serializer for the
//                composite TV output. Keeps one prefetched word ahead of the
//                word being displayed; pixel for (xpos, ypos) appears on
//                pix_out one pixel tick after that position is presented.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n            : 50 MHz clock, synchronous active-low reset
//    pix_en                : one-clk pixel strobe (every 5th clk)
//    xpos, ypos, active    : raster position from the output stage
//    vram_req, vram_addr   : read request {line, word}, held until ack
//    vram_ack, vram_rdata  : one-cycle acknowledge with read data
//    pix_out               : serialized pixel (registered)
//    underrun_clr          : clears the sticky underrun flag
//    underrun              : sticky, a word was not available when needed
// ============================================================================
module tv_pixel_fetch
    import tv_pkg::*;
#(
    parameter int LINE_PREFETCH_X = 520
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_en,
    input  logic [9:0]           xpos,
    input  logic [8:0]           ypos,
    input  logic                 active,
    output logic                 vram_req,
    output logic [VRAM_AW-1:0]   vram_addr,
    input  logic                 vram_ack,
    input  logic [WORD_BITS-1:0] vram_rdata,
    output logic                 pix_out,
    input  logic                 underrun_clr,
    output logic                 underrun
);

    // Last column whose word boundary still has a following word to fetch
    localparam logic [9:0] WORD_FETCH_LIMIT = 10'(H_ACTIVE - WORD_BITS);
    localparam logic [9:0] LINE_FETCH_X     = 10'(LINE_PREFETCH_X);
    localparam logic [8:0] LAST_LINE        = 9'(V_TOTAL - 1);
    localparam logic [8:0] ACTIVE_LINES     = 9'(V_ACTIVE);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [WORD_BITS-1:0] next_word;
    logic                 next_valid;
    logic                 stale;

    logic                 word_start;
    logic                 word_trig;
    logic                 line_trig;
    logic                 fetch_trig;
    logic [4:0]           word_target_idx;
    logic [8:0]           next_line;
    logic [VRAM_AW-1:0]   fetch_target;

    logic                 issue;
    logic                 ack_take;
    logic                 trig_blocked;

    logic                 load_word;
    logic                 advance;
    logic                 blank;

    // ------------------------------------------------------------------
    // Fetch triggers (only meaningful on pix_en cycles)
    // ------------------------------------------------------------------
    assign word_start      = (xpos[3:0] == 4'd0);
    assign word_target_idx = xpos[8:4] + 5'd1;
    assign word_trig       = pix_en & active & word_start & (xpos < WORD_FETCH_LIMIT);

    assign next_line       = (ypos == LAST_LINE) ? 9'd0 : ypos + 9'd1;
    assign line_trig       = pix_en & (xpos == LINE_FETCH_X) & (next_line < ACTIVE_LINES);

    // Word and line triggers are mutually exclusive (x < 512 vs x >= 512)
    assign fetch_trig      = word_trig | line_trig;
    assign fetch_target    = line_trig ? {next_line, 5'd0} : {ypos, word_target_idx};

    // ------------------------------------------------------------------
    // Fetch FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE: if (fetch_trig) state_next = FETCH_REQ;
            FETCH_REQ:  if (vram_ack)   state_next = FETCH_IDLE;
            default:                    state_next = FETCH_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch FSM: outputs
    // ------------------------------------------------------------------
    // An ack is only honoured while a request is outstanding, so a stray
    // ack after reset is ignored. A trigger that lands while busy is
    // dropped; if the outstanding read has not yet completed, its data is
    // now for a word already due and must be discarded (stale). When the
    // ack coincides with the trigger there is nothing left to discard.
    always_comb begin
        vram_req     = 1'b0;
        issue        = 1'b0;
        ack_take     = 1'b0;
        trig_blocked = 1'b0;
        case (state)
            FETCH_IDLE: begin
                issue = fetch_trig;
            end
            FETCH_REQ: begin
                vram_req     = 1'b1;
                ack_take     = vram_ack;
                trig_blocked = fetch_trig & ~vram_ack;
            end
            default: begin
                vram_req = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Prefetch buffer, address latch and underrun flag
    // ------------------------------------------------------------------
    assign load_word = pix_en & active & word_start;
    assign advance   = pix_en & active & ~word_start;
    assign blank     = pix_en & ~active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vram_addr  <= '0;
            next_word  <= '0;
            next_valid <= 1'b0;
            stale      <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (issue) begin
                vram_addr <= fetch_target;
            end

            if (ack_take) begin
                stale <= 1'b0;
            end else if (trig_blocked) begin
                stale <= 1'b1;
            end

            // Load consumes the old next_valid; a same-cycle ack refills it.
            if (load_word) begin
                next_valid <= 1'b0;
            end
            if (ack_take && !stale) begin
                next_word  <= vram_rdata;
                next_valid <= 1'b1;
            end

            // Set has priority over clear
            if (load_word && !next_valid) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer; an empty buffer displays black
    // ------------------------------------------------------------------
    tv_shift16 u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_word),
        .advance   (advance),
        .blank     (blank),
        .load_data (next_valid ? next_word : {WORD_BITS{1'b0}}),
        .bit_out   (pix_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_tv_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tv_pixel_fetch
//  Description : Self-checking bench for tv_pixel_fetch. Drives the raster
//                pixel by pixel, emulates a VRAM with programmable latency,
//                and compares every pixel against a framebuffer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tv_pixel_fetch;
    import tv_pkg::*;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        pix_en       = 1'b0;
    logic [9:0]  xpos         = '0;
    logic [8:0]  ypos         = '0;
    logic        active       = 1'b0;
    logic        vram_ack     = 1'b0;
    logic [15:0] vram_rdata   = '0;
    logic        underrun_clr = 1'b0;
    logic        vram_req;
    logic [13:0] vram_addr;
    logic        pix_out;
    logic        underrun;

    int tests    = 0;
    int failures = 0;

    // Framebuffer image and VRAM responder controls
    logic [15:0] mem [0:16383];
    int          lat_word [0:31];
    int          lat_line = 1;
    bit          bad [0:31];
    bit          hold_ack   = 1'b0;
    bit          force_ack  = 1'b0;
    logic [15:0] force_data = '0;
    int          req_age = 0;
    int          cur_lat = 1;
    int          served  = 0;
    bit          ur_exp  = 1'b0;

    tv_pixel_fetch #(.LINE_PREFETCH_X(520)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_en       (pix_en),
        .xpos         (xpos),
        .ypos         (ypos),
        .active       (active),
        .vram_req     (vram_req),
        .vram_addr    (vram_addr),
        .vram_ack     (vram_ack),
        .vram_rdata   (vram_rdata),
        .pix_out      (pix_out),
        .underrun_clr (underrun_clr),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clk cycle. Inputs change on the falling edge; the VRAM emulation
    // acks a request once it has been high for its chosen latency.
    task automatic cycle(input logic en);
        @(negedge clk);
        pix_en   = en;
        vram_ack = 1'b0;
        if (vram_req !== 1'b1) req_age = 0;
        if (force_ack) begin
            vram_ack   = 1'b1;
            vram_rdata = force_data;
            force_ack  = 1'b0;
            req_age    = 0;
        end else if (vram_req === 1'b1 && !hold_ack) begin
            if (req_age == 0)
                cur_lat = (vram_addr[4:0] == 5'd0) ? lat_line : lat_word[vram_addr[4:0]];
            req_age++;
            if (req_age >= cur_lat) begin
                vram_ack   = 1'b1;
                vram_rdata = mem[vram_addr];
                served++;
                req_age    = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        xpos   = 10'(x);
        ypos   = 9'(y);
        active = (x < H_ACTIVE) && (y < V_ACTIVE);
        cycle(1'b1);
    endtask

    task automatic idle4();
        repeat (4) cycle(1'b0);
    endtask

    // Timeline model of one active line: word w is requested 80 clk before
    // it is due, only if the previous read has already completed, and it
    // arrives in time only if its latency is under 80 clk.
    task automatic plan_line();
        int busy_end;
        int t;
        busy_end = -1;
        bad[0]   = 1'b0;
        for (int w = 1; w < 32; w++) begin
            t = 80 * (w - 1);
            if (t > busy_end) begin
                busy_end = t + lat_word[w];
                bad[w]   = (lat_word[w] >= 80);
            end else begin
                bad[w] = 1'b1;
            end
        end
    endtask

    function automatic logic exp_pix(input int x, input int y);
        logic [15:0] w;
        if (x >= H_ACTIVE || y >= V_ACTIVE) return 1'b0;
        if (bad[x / 16]) return 1'b0;
        w = mem[y * 32 + x / 16];
        return w[15 - (x % 16)];
    endfunction

    task automatic run_line(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            pix(x, y);
            if (x < H_ACTIVE && y < V_ACTIVE && (x % 16) == 0 && bad[x / 16]) ur_exp = 1'b1;
            chk("pix_out", pix_out, exp_pix(x, y));
            chk("underrun", underrun, ur_exp);
            idle4();
        end
    endtask

    initial begin
        int          served_before;
        logic [15:0] word_a;
        logic [15:0] word_b;
        logic [15:0] word_c;
        logic        e;

        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h8001;
        mem[1] = 16'hFFFF;
        for (int w = 0; w < 32; w++) lat_word[w] = 1;
        lat_line = 1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) cycle(1'b0);
        chk("rst_pix_out", pix_out, 0);
        chk("rst_vram_req", vram_req, 0);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_underrun", underrun, 0);
        rst_n = 1'b1;

        // Frame wrap: last line requests line 0 word 0
        run_line(308, 512, 519);
        pix(520, 308);
        chk("wrap_req", vram_req, 1);
        chk("wrap_addr", vram_addr, 0);
        idle4();
        run_line(308, 521, 639);

        // Nominal line 0 at 1-clk latency
        plan_line();
        run_line(0, 0, 639);

        // Random image, random in-time latencies
        for (int y = 1; y <= 3; y++) begin
            for (int w = 0; w < 32; w++) lat_word[w] = $urandom_range(1, 70);
            lat_line = $urandom_range(1, 100);
            plan_line();
            run_line(y, 0, 639);
        end

        // Slow VRAM: word 3 acked after 85 clk
        for (int w = 0; w < 32; w++) lat_word[w] = 2;
        lat_word[3] = 85;
        lat_line    = 3;
        plan_line();
        run_line(4, 0, 639);
        chk("slow_underrun", underrun, 1);
        underrun_clr = 1'b1;
        cycle(1'b0);
        underrun_clr = 1'b0;
        ur_exp = 1'b0;
        chk("underrun_clr", underrun, 0);

        // Last active line: no fetch for line 287
        served_before = served;
        run_line(286, 512, 639);
        chk("no_line287_fetch", served - served_before, 0);
        chk("no_line287_req", vram_req, 0);

        // Ack coincident with a load: buffer holds word A, a second fetch
        // of the same line start returns B exactly on the x=0 load edge.
        lat_line = 1;
        for (int w = 0; w < 32; w++) lat_word[w] = 5;
        run_line(9, 512, 639);
        word_a   = mem[10 * 32];
        word_b   = word_a ^ 16'hA5C3;
        word_c   = mem[10 * 32 + 2];
        hold_ack = 1'b1;
        pix(520, 9);
        chk("coinc_second_req", vram_req, 1);
        idle4();
        run_line(9, 521, 639);
        hold_ack   = 1'b0;
        force_data = word_b;
        force_ack  = 1'b1;
        for (int x = 0; x < 48; x++) begin
            pix(x, 10);
            if (x < 16)      e = word_a[15 - x];
            else if (x < 32) e = word_b[31 - x];
            else             e = word_c[47 - x];
            chk("coinc_pix", pix_out, e);
            chk("coinc_underrun", underrun, 0);
            idle4();
        end

        // Reset while a request is pending
        hold_ack = 1'b1;
        pix(0, 20);
        idle4();
        pix(16, 20);
        chk("pre_rst_underrun", underrun, 1);
        chk("pre_rst_req", vram_req, 1);
        chk("pre_rst_addr", vram_addr, 20 * 32 + 1);
        idle4();
        rst_n = 1'b0;
        cycle(1'b0);
        rst_n = 1'b1;
        chk("midreq_rst_req", vram_req, 0);
        chk("midreq_rst_pix", pix_out, 0);
        chk("midreq_rst_underrun", underrun, 0);
        chk("midreq_rst_addr", vram_addr, 0);
        force_data = 16'hFFFF;
        force_ack  = 1'b1;
        cycle(1'b0);
        idle4();
        // Empty buffer must show on the next load; clear loses to set
        underrun_clr = 1'b1;
        pix(0, 21);
        chk("late_ack_ignored_pix", pix_out, 0);
        chk("set_beats_clr", underrun, 1);
        underrun_clr = 1'b0;
        idle4();
        underrun_clr = 1'b1;
        cycle(1'b0);
        underrun_clr = 1'b0;
        chk("final_clr", underrun, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tv_pixel_fetch.md
# tv_pixel_fetch

Video-RAM fetch and pixel serializer for the composite TV output path. It sits directly upstream of the sync/video output stage and shares that stage's 50 MHz clock, its 10 MHz pixel strobe and its 640×309 raster counters. For each pixel it delivers one monochrome bit from a 512×287 1-bpp framebuffer, one pixel tick after the matching position is presented. The output stage already applies that one-tick delay to its active and sync signals. VRAM is read 16 pixels at a time through a request/acknowledge port that may be stalled by other masters.

## Interface
- `LINE_PREFETCH_X`, default 520: xpos at which word 0 of the next line is requested; must be ≥ 512 and < 640.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: **one clock; reset is synchronous and active-low**.
- `pix_en` in 1: one-`clk` pixel strobe, every 5th cycle.
- `xpos` in 10: current pixel column, 0..639, changes only after a `pix_en` cycle.
- `ypos` in 9: current line, 0..308.
- `active` in 1: high when xpos < 512 and ypos < 287.
- `vram_req` out 1: read request, held until acknowledged.
- `vram_addr` out 14: word address {line[8:0], word[4:0]}, stable while `vram_req` is high.
- `vram_ack` in 1: one-cycle pulse; `vram_rdata` is valid in the same cycle.
- `vram_rdata` in 16: read word; bit 15 is the leftmost pixel.
- `pix_out` out 1: serialized pixel, registered.
- `underrun_clr` in 1: clears `underrun`.
- `underrun` out 1: sticky; a needed word was not fetched in time.

## Operation
- Storage:
  - `shift` (16 bits) holds the word currently being displayed.
  - `next_word` (16 bits) plus a `next_valid` flag hold the prefetched word.
- Fetch FSM states:
  - IDLE to REQ on a trigger; the address is latched and `vram_req` is set.
  - REQ to IDLE on `vram_ack`.
- Triggers, evaluated only on `pix_en` cycles:
  - Word prefetch: active, xpos[3:0] == 0 and xpos < 496. Target is {ypos, xpos[8:4]+1}.
  - Line prefetch: xpos == `LINE_PREFETCH_X`. Compute ny = (ypos == 308) ? 0 : ypos+1. Trigger only if ny < 287; target is {ny, 0}.
- On ack with `stale` clear:
  - next_word ← vram_rdata, next_valid ← 1.
- Trigger arriving while in REQ:
  - No new request is issued and `stale` ← 1.
  - The outstanding ack's data is then discarded and `stale` is cleared.
  - `underrun` is set when that skipped word is loaded.
- Load, on a `pix_en` cycle with active and xpos[3:0] == 0:
  - next_valid = 1: shift ← next_word, next_valid ← 0.
  - next_valid = 0: shift ← 0, underrun ← 1.
  - pix_out ← the new shift[15]; shift then shifts left by one.
- Other `pix_en` cycles with active: pix_out ← shift[15], shift ← shift << 1.
- `pix_en` cycles with active low: pix_out ← 0.
- Ack and load in the same cycle: the load sees the old next_valid, and the ack's write takes effect. The bench must cover this case.
- `underrun_clr` and a new underrun event in the same cycle: set wins.
- Reset, including mid-request:
  - Outputs: pix_out 0, vram_req 0, vram_addr 0, underrun 0.
  - Internal: FSM IDLE, shift 0, next_word 0, next_valid 0, stale 0.
  - A VRAM ack arriving after reset is ignored.

## Timing
- The pixel for position (x, y) appears on pix_out after the `pix_en` edge at which (x, y) is presented. It stays valid for 5 `clk` cycles, aligned with the output stage's delayed active signal.
- Fetch deadlines:
  - Word prefetch: ack within 16 pixel ticks (80 `clk`) to avoid underrun.
  - Line prefetch: 640 − `LINE_PREFETCH_X` ticks.
- Minimum VRAM latency is 1 `clk`, meaning ack in the cycle after `vram_req` rises.
- `vram_req` deasserts in the cycle after the ack.

## Structure
- Shared `tv_pkg` holds the raster constants, which the output stage also uses:
  - H_ACTIVE = 512, H_TOTAL = 640, V_ACTIVE = 287, V_TOTAL = 309.
  - WORD_BITS = 16, VRAM_AW = 14.
  - Fetch FSM state enum.
- One natural sub-module: `tv_shift16`, the load/shift register with MSB-first output.

## Test plan
- Nominal line: words 0x8001, 0xFFFF, …, ack at 1-clk latency. pix_out for x = 0..15 is 1,0…0,1, and underrun stays 0 for the full frame.
- Slow VRAM: word 3 acked 85 clk after its request. Pixels 48..63 are 0, underrun = 1, and the late data is discarded (stale path). underrun_clr then drops underrun to 0.
- Frame wrap: ypos 308 at xpos 520 requests addr {0, 0}. ypos 286 at xpos 520 issues no request for line 287.
- Reset asserted while vram_req is high: the next cycle has vram_req 0, pix_out 0 and underrun 0, and a subsequent ack has no effect.
- Ack coincident with a load `pix_en` cycle: shift loads the previous word and next_word captures the new one. The following 16 pixels have no underrun.
